// File: rtl/audio_pwm_pkg.sv
// Shared register map, STATUS layout and PWM constants for the audio PWM output peripheral.
package audio_pwm_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_UNDERRUN = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_LEVEL    = 16;
  localparam int ST_LEVEL_W  = 9;

  localparam logic [15:0] DIV_MIN  = 16'd256;
  localparam int          PWM_BITS = 8;

  // Signed sample to offset-binary duty: top byte with the sign bit flipped.
  function automatic logic [PWM_BITS-1:0] sample_to_duty(input logic [15:0] sample);
    return sample[15:8] ^ 8'h80;
  endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Register bus between the interconnect slice and the audio PWM peripheral.
// Reads return on rd one cycle after addr; writes never stall.
interface audio_pwm_out_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, addr, wd, input rd);
  modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata valid combinationally while !empty.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output: sample FIFO drained by a programmable rate timer, rendered as 8-bit PWM.
// Register reads have 1-cycle latency; writes never stall, overflowing pushes are dropped.
module audio_pwm_out
  import audio_pwm_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd6250,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  audio_pwm_out_if.slave    bus,
  output logic              pwm_out,
  output logic              underrun
);

  logic [1:0]          reg_sel;
  logic                push_req;
  logic                status_wr;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_level;
  logic [15:0]         fifo_rdata;
  logic                ctrl_en;
  logic [15:0]         div_q;
  logic [15:0]         tmr;
  logic                tick;
  logic                pop;
  logic                overflow;
  logic [15:0]         cur_sample;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [31:0]         status;
  logic [31:0]         rd_nxt;
  logic [31:0]         rd_q;
  logic                unused_bits;

  assign reg_sel     = bus.addr[3:2];
  assign push_req    = bus.we && (reg_sel == REG_DATA);
  assign status_wr   = bus.we && (reg_sel == REG_STATUS);
  assign tick        = ctrl_en && (tmr == div_q - 16'd1);
  assign pop         = tick && !fifo_empty;
  assign bus.rd      = rd_q;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wd[31:16]};

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (bus.wd[15:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status                         = '0;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_FULL]                = fifo_full;
    status[ST_UNDERRUN]            = underrun;
    status[ST_OVERFLOW]            = overflow;
    status[ST_LEVEL +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
    case (reg_sel)
      REG_STATUS: rd_nxt = status;
      REG_CTRL:   rd_nxt = {31'd0, ctrl_en};
      REG_DIV:    rd_nxt = {16'd0, div_q};
      default:    rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      ctrl_en  <= 1'b0;
      div_q    <= DIV_RESET;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_q <= rd_nxt;
      if (bus.we && reg_sel == REG_CTRL) ctrl_en <= bus.wd[0];
      if (bus.we && reg_sel == REG_DIV)
        div_q <= (bus.wd[15:0] < DIV_MIN) ? DIV_MIN : bus.wd[15:0];
      // A set in the same cycle as a write-1-to-clear takes precedence.
      underrun <= (tick && fifo_empty) ||
                  (underrun && !(status_wr && bus.wd[ST_UNDERRUN]));
      overflow <= (push_req && fifo_full && !pop) ||
                  (overflow && !(status_wr && bus.wd[ST_OVERFLOW]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr        <= '0;
      cur_sample <= '0;
    end else begin
      if (!ctrl_en || tmr >= div_q - 16'd1) tmr <= '0;
      else                                  tmr <= tmr + 16'd1;
      if (pop) cur_sample <= fifo_rdata;
    end
  end

  // Duty only changes at a PWM period boundary (or while idle) so no period is torn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= sample_to_duty(16'd0);
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= ctrl_en ? pwm_cnt + 1'b1 : '0;
      if (!ctrl_en || pwm_cnt == '1) duty_q <= sample_to_duty(cur_sample);
      pwm_out <= ctrl_en && (pwm_cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: register map, FIFO limits, sample pacing, PWM duty and underrun.
module tb_audio_pwm_out;
  import audio_pwm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_out;
  logic        underrun;
  logic [31:0] v;
  logic [31:0] exp_st;
  int          checks = 0;
  int          errors = 0;
  int          highs;
  int          lvl;
  int          exp_q[$];

  audio_pwm_out_if bus();

  audio_pwm_out #(.DEPTH(16), .DIV_RESET(16'd6250)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pwm_out  (pwm_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [1:0] r);
    return {28'hA5A5A5A, r, 2'b01};
  endfunction

  function automatic int duty_of(input logic [15:0] s);
    logic [7:0] hi;
    hi = s[15:8];
    return int'(hi ^ 8'h80);
  endfunction

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = reg_addr(r);
    bus.wd   = d;
    @(negedge clk);
    bus.we   = 1'b0;
  endtask

  task automatic rdreg(input logic [1:0] r, output logic [31:0] val);
    @(negedge clk);
    bus.we   = 1'b0;
    bus.addr = reg_addr(r);
    @(negedge clk);
    val = bus.rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd", bus.rd, 32'd0);
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    rdreg(REG_STATUS, v); check("rst_status", v, 32'h1);
    rdreg(REG_CTRL, v);   check("rst_ctrl", v, 32'h0);
    rdreg(REG_DIV, v);    check("rst_div", v, 32'd6250);
    rdreg(REG_DATA, v);   check("data_read_zero", v, 32'h0);

    // DIV clamp and read latency
    wr(REG_DIV, 32'd10);  rdreg(REG_DIV, v); check("div_clamp_10", v, 32'd256);
    wr(REG_DIV, 32'd255); rdreg(REG_DIV, v); check("div_clamp_255", v, 32'd256);
    wr(REG_DIV, 32'd257); rdreg(REG_DIV, v); check("div_257", v, 32'd257);
    rdreg(REG_CTRL, v);   check("ctrl_before_lat", v, 32'h0);
    @(negedge clk);
    bus.addr = reg_addr(REG_DIV);
    #1 check("lat_not_early", bus.rd, 32'd0);
    @(posedge clk);
    #1 check("lat_one_cycle", bus.rd, 32'd257);

    // Push beyond full, then clear overflow
    for (int i = 0; i < 17; i++) wr(REG_DATA, 32'(i * 16'h0111));
    rdreg(REG_STATUS, v); check("overflow_status", v, 32'h0010_000A);
    wr(REG_STATUS, 32'h8);
    rdreg(REG_STATUS, v); check("overflow_cleared", v, 32'h0010_0002);

    // Push coinciding with a pop at level 16
    wr(REG_DIV, 32'd256);
    wr(REG_CTRL, 32'd1);
    repeat (254) @(negedge clk);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = reg_addr(REG_DATA); bus.wd = 32'h1234;
    @(negedge clk);
    bus.we = 1'b0;
    rdreg(REG_STATUS, v); check("full_push_pop", v, 32'h0010_0002);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) wr(REG_DATA, 32'h2000 + 32'(i));
    wr(REG_CTRL, 32'd1);
    repeat (300) @(negedge clk);
    check("pre_reset_rd", bus.rd, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rd", bus.rd, 32'd0);
    check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
    reset = 1'b0;
    rdreg(REG_STATUS, v); check("midrst_status", v, 32'h1);
    rdreg(REG_CTRL, v);   check("midrst_ctrl", v, 32'h0);
    rdreg(REG_DIV, v);    check("midrst_div", v, 32'd6250);

    // Sample pacing: DIV=300, pops at 300 and 600 cycles after enable
    exp_q.delete();
    exp_q.push_back(128); exp_q.push_back(128);
    wr(REG_DIV, 32'd300);
    wr(REG_DATA, 32'h7FFF); exp_q.push_back(duty_of(16'h7FFF));
    wr(REG_DATA, 32'h8000); exp_q.push_back(duty_of(16'h8000));
    wr(REG_CTRL, 32'd1);
    bus.addr = reg_addr(REG_STATUS);
    highs = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      if (pwm_out) highs++;
      if (k % 256 == 0) begin
        check($sformatf("pace_win%0d_highs", k / 256), 32'(highs), 32'(exp_q.pop_front()));
        highs = 0;
      end
      if (k == 300 || k == 301 || k == 600 || k == 601) begin
        lvl = 2 - (k - 1) / 300;
        if (lvl < 0) lvl = 0;
        exp_st = {7'd0, 9'(lvl), 16'd0} | ((lvl == 0) ? 32'h1 : 32'h0);
        check($sformatf("pace_status_k%0d", k), bus.rd, exp_st);
      end
      if (k == 899) check("pace_no_underrun_yet", {31'd0, underrun}, 32'd0);
      if (k == 900) check("pace_underrun_set", {31'd0, underrun}, 32'd1);
    end

    // Underrun from empty FIFO at DIV=256, then a late 0x4000 sample
    do_reset();
    exp_q.delete();
    exp_q.push_back(128); exp_q.push_back(128); exp_q.push_back(128);
    wr(REG_DIV, 32'd256);
    wr(REG_CTRL, 32'd1);
    highs = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      if (k == 300) begin
        bus.we = 1'b1; bus.addr = reg_addr(REG_DATA); bus.wd = 32'h4000;
        exp_q.push_back(duty_of(16'h4000));
      end
      if (k == 301) bus.we = 1'b0;
      if (pwm_out) highs++;
      if (k % 256 == 0) begin
        check($sformatf("urun_win%0d_highs", k / 256), 32'(highs), 32'(exp_q.pop_front()));
        highs = 0;
      end
      if (k == 255) check("urun_before_tick", {31'd0, underrun}, 32'd0);
      if (k == 256) check("urun_after_tick", {31'd0, underrun}, 32'd1);
    end
    wr(REG_CTRL, 32'd0);
    @(negedge clk);
    check("disable_pwm_low", {31'd0, pwm_out}, 32'd0);
    wr(REG_STATUS, 32'h4);
    check("urun_cleared", {31'd0, underrun}, 32'd0);
    rdreg(REG_STATUS, v); check("urun_status_after_clear", v, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
